fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generator, 1-cycle ROM interface,
// and a small {instr, pc} FIFO presented to decode over valid/ready.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]      NOP      = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_en,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     imem_req,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [WIDTH-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];

    logic [CNT_W:0]   pending;
    logic             push, pop;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        pending   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_valid_q};
        imem_req  = !rst && !redirect_en && (pending < DEPTH_W);
        imem_addr = fetch_pc_q;
        out_valid = (count_q != '0) && !redirect_en;
        out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;
        out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
        occupancy = count_q;
        push      = !rst && inflight_valid_q && !redirect_en;
        pop       = !rst && out_valid && out_ready;
    end

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = 1'b0;
        inflight_pc_d    = inflight_pc_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        if (rst) begin
            fetch_pc_d = RESET_PC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else if (redirect_en) begin
            // Wrong-path queue contents and the in-flight word are both dropped.
            fetch_pc_d = redirect_pc & ~WIDTH'(3);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                inflight_valid_d = 1'b1;
                inflight_pc_d    = fetch_pc_q;
                fetch_pc_d       = fetch_pc_q + WIDTH'(4);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        fetch_pc_q       <= fetch_pc_d;
        inflight_valid_q <= inflight_valid_d;
        inflight_pc_q    <= inflight_pc_d;
        rd_ptr_q         <= rd_ptr_d;
        wr_ptr_q         <= wr_ptr_d;
        count_q          <= count_d;
    end

    // NOTE: FIFO storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the expected delivered stream is a sequential
// PC run restarted by every reset/redirect, each PC paired with its ROM word.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;

    logic        redirect_en2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
    logic        out_ready2   = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic [2:0]  occupancy2;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_accepted = 0;
    logic [31:0] exp_q [$];
    logic [63:0] seen2 [$];

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(NOP)) u_dut (
        .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .occupancy(occupancy)
    );

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP)) u_dut_wrap (
        .clk(clk), .rst(rst), .redirect_en(redirect_en2), .redirect_pc(redirect_pc2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .occupancy(occupancy2)
    );

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Synchronous ROMs: garbage when no request, so only requested words are valid.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? rom(imem_addr)  : $urandom();
        imem_rdata2 <= imem_req2 ? rom(imem_addr2) : $urandom();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(pc & ~32'd3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must be the next PC of the current stream.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (!rst) begin
            check("occ_bound", 64'(occupancy <= 3'd4), 64'd1);
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", 64'd0, 64'd1);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        check("out_pc", 64'(out_pc), 64'(exp_pc));
                        check("out_instr", 64'(out_instr), 64'(rom(exp_pc)));
                        exp_q.push_back(exp_pc + 32'd4);
                        n_accepted++;
                    end
                end
            end else begin
                check("idle_instr", 64'(out_instr), 64'(NOP));
                check("idle_pc", 64'(out_pc), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && seen2.size() < 3)
            seen2.push_back({out_pc2, out_instr2});
    end

    initial begin
        int gaps;
        int waited;
        logic [31:0] target;
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("req_in_rst", 64'(imem_req), 64'd0);

        // Startup: rst low in C0, head valid in C2.
        step();
        rst = 1'b0; out_ready = 1'b1; restart_stream(32'h0);
        @(negedge clk);
        check("c0_occ", 64'(occupancy), 64'd0);
        check("c0_valid", 64'(out_valid), 64'd0);
        check("c0_instr", 64'(out_instr), 64'(NOP));
        check("c0_pc", 64'(out_pc), 64'd0);
        check("c0_addr", 64'(imem_addr), 64'd0);
        check("c0_req", 64'(imem_req), 64'd1);
        @(negedge clk);
        check("c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("c2_valid", 64'(out_valid), 64'd1);
        check("c2_pc", 64'(out_pc), 64'd0);

        gaps = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid) gaps++;
        end
        check("no_gaps", 64'(gaps), 64'd0);

        // Backpressure: queue fills, requests stop, resume one cycle after first pop.
        step();
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("full_occ", 64'(occupancy), 64'd4);
        check("full_req", 64'(imem_req), 64'd0);
        check("full_valid", 64'(out_valid), 64'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("resume_req", 64'(imem_req), 64'd1);
        repeat (8) step();

        // Redirect on a full queue.
        out_ready = 1'b0;
        repeat (8) step();
        check("pre_redir_occ", 64'(occupancy), 64'd4);
        redirect_en = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        restart_stream(32'h40);
        @(negedge clk);
        check("redir_valid", 64'(out_valid), 64'd0);
        check("redir_req", 64'(imem_req), 64'd0);
        step();
        redirect_en = 1'b0;
        @(negedge clk);
        check("r1_occ", 64'(occupancy), 64'd0);
        check("r1_addr", 64'(imem_addr), 64'h40);
        check("r1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("r2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("r3_valid", 64'(out_valid), 64'd1);
        check("r3_pc", 64'(out_pc), 64'h40);

        // Redirect to an unaligned target while streaming with a valid head and ready=1.
        repeat (5) step();
        redirect_en = 1'b1; redirect_pc = 32'h42;
        restart_stream(32'h42);
        @(negedge clk);
        check("redir2_valid", 64'(out_valid), 64'd0);
        step();
        redirect_en = 1'b0;
        @(negedge clk);
        check("redir2_addr", 64'(imem_addr), 64'h40);
        check("redir2_occ", 64'(occupancy), 64'd0);

        // Random backpressure and redirects, including targets near the top of the space.
        for (int i = 0; i < 400; i++) begin
            step();
            out_ready = ($urandom_range(9) < 7);
            if ($urandom_range(31) == 0) begin
                target = $urandom();
                if ($urandom_range(3) == 0) target = 32'hFFFF_FFF0 | (target & 32'hF);
                redirect_en = 1'b1;
                redirect_pc = target;
                restart_stream(target);
            end else begin
                redirect_en = 1'b0;
            end
        end

        // Empty the queue, let it reach 3 entries, then rst and redirect together.
        step();
        redirect_en = 1'b1; redirect_pc = 32'h100; out_ready = 1'b0;
        restart_stream(32'h100);
        step();
        redirect_en = 1'b0;
        waited = 0;
        while (occupancy != 3'd3 && waited < 20) begin
            step();
            waited++;
        end
        check("reach_occ3", 64'(occupancy), 64'd3);
        rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
        step();
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'(NOP));
        check("rst_addr", 64'(imem_addr), 64'd0);
        rst = 1'b0; redirect_en = 1'b0; out_ready = 1'b1;
        restart_stream(32'h0);
        repeat (20) step();

        check("wrap_seen", 64'(seen2.size()), 64'd3);
        if (seen2.size() == 3) begin
            check("wrap_pc0", seen2[0], {32'hFFFF_FFFC, rom(32'hFFFF_FFFC)});
            check("wrap_pc1", seen2[1], {32'h0000_0000, rom(32'h0)});
            check("wrap_pc2", seen2[2], {32'h0000_0004, rom(32'h4)});
        end
        check("accepted_some", 64'(n_accepted > 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
